// File: rtl/aes_pkg.sv
// Shared AES type definitions used by the MixColumns sequencer and its interface.
package aes_pkg;

  typedef enum logic [1:0] {
    CIPH_FWD = 2'b01,
    CIPH_INV = 2'b10
  } ciph_op_e;

endpackage

// File: rtl/aes_mix_columns_seq_if.sv
// Handshake bundle for aes_mix_columns_seq: input state, output state and status.
interface aes_mix_columns_seq_if;

  logic                   in_valid_i;
  logic                   in_ready_o;
  aes_pkg::ciph_op_e      op_i;
  logic [3:0][3:0][7:0]   data_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [3:0][3:0][7:0]   data_o;
  logic                   busy_o;
  logic                   err_o;

  modport master (
    output in_valid_i, op_i, data_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, busy_o, err_o
  );

  modport slave (
    input  in_valid_i, op_i, data_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, busy_o, err_o
  );

endinterface

// File: rtl/aes_mix_columns_seq.sv
// Time-multiplexed AES (Inv)MixColumns over a 128-bit state using NumUnits column units.
// Optional macro AES_MIXCOL_SEQ_WIPE_EN wipes the buffer on handoff and masks data_o when not valid.
module aes_mix_single_column (
  input  aes_pkg::ciph_op_e op_i,
  input  logic [3:0][7:0]   data_i,
  output logic [3:0][7:0]   data_o
);

  function automatic logic [7:0] aes_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] aes_mul4(input logic [7:0] b);
    return aes_mul2(aes_mul2(b));
  endfunction

  logic [3:0][7:0] x;
  logic [3:0][7:0] x_mul2;
  logic [1:0][7:0] y;
  logic [1:0][7:0] z;
  logic [1:0][7:0] z_muxed;
  logic [7:0]      y2;

  assign x[0] = data_i[0] ^ data_i[3];
  assign x[1] = data_i[3] ^ data_i[2];
  assign x[2] = data_i[2] ^ data_i[1];
  assign x[3] = data_i[1] ^ data_i[0];

  assign x_mul2[0] = aes_mul2(x[0]);
  assign x_mul2[1] = aes_mul2(x[1]);
  assign x_mul2[2] = aes_mul2(x[2]);
  assign x_mul2[3] = aes_mul2(x[3]);

  // Inverse = forward + 4*(a0^a2), 4*(a1^a3) corrections folded into z.
  assign y[0] = aes_mul4(data_i[3] ^ data_i[1]);
  assign y[1] = aes_mul4(data_i[2] ^ data_i[0]);
  assign y2   = aes_mul2(y[0] ^ y[1]);
  assign z[0] = y2 ^ y[0];
  assign z[1] = y2 ^ y[1];

  assign z_muxed = (op_i == aes_pkg::CIPH_INV) ? z : '0;

  assign data_o[0] = data_i[1] ^ x_mul2[3] ^ x[1] ^ z_muxed[1];
  assign data_o[1] = data_i[0] ^ x_mul2[2] ^ x[1] ^ z_muxed[0];
  assign data_o[2] = data_i[3] ^ x_mul2[1] ^ x[3] ^ z_muxed[1];
  assign data_o[3] = data_i[2] ^ x_mul2[0] ^ x[3] ^ z_muxed[0];

endmodule

module aes_mix_columns_seq #(
  parameter int NumUnits = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  aes_mix_columns_seq_if.slave bus
);

  localparam bit       NumUnitsOk = (NumUnits == 1) || (NumUnits == 2) || (NumUnits == 4);
  localparam int       Cycles     = NumUnitsOk ? (4 / NumUnits) : 4;
  localparam int       Units      = NumUnitsOk ? NumUnits : 1;
  localparam bit [1:0] CntLast    = 2'(Cycles - 1);

  if (!NumUnitsOk) begin : g_bad_num_units
    $error("aes_mix_columns_seq: NumUnits must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [3:0][3:0][7:0]  buf_q, buf_d;
  aes_pkg::ciph_op_e     op_q, op_d;
  logic                  err_q, err_d;

  logic [1:0]            col_idx [Units];
  logic [3:0][7:0]       col_in  [Units];
  logic [3:0][7:0]       col_out [Units];

  // Unit k owns column cnt*Units+k in the current BUSY cycle.
  for (genvar k = 0; k < Units; k++) begin : g_unit
    assign col_idx[k] = 2'(int'(cnt_q) * Units + k);
    assign col_in[k]  = buf_q[col_idx[k]];

    aes_mix_single_column u_col (
      .op_i   (op_q),
      .data_i (col_in[k]),
      .data_o (col_out[k])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      op_q    <= aes_pkg::CIPH_FWD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    op_d    = op_q;
    err_d   = err_q;
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      buf_d   = '0;
      op_d    = aes_pkg::CIPH_FWD;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            buf_d   = bus.data_i;
            op_d    = bus.op_i;
            err_d   = !(bus.op_i inside {aes_pkg::CIPH_FWD, aes_pkg::CIPH_INV});
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          for (int k = 0; k < Units; k++) begin
            buf_d[col_idx[k]] = col_out[k];
          end
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            state_d = IDLE;
`ifdef AES_MIXCOL_SEQ_WIPE_EN
            buf_d   = '0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready_o  = (state_q == IDLE);
    bus.out_valid_o = (state_q == DONE);
    bus.busy_o      = (state_q == BUSY) || (state_q == DONE);
    bus.err_o       = (state_q == DONE) && err_q;
`ifdef AES_MIXCOL_SEQ_WIPE_EN
    bus.data_o      = (state_q == DONE) ? buf_q : '0;
`else
    bus.data_o      = buf_q;
`endif
  end

endmodule
